// File: rtl/fixed_point_sat_round_if.sv
// Stream bundle for fixed_point_sat_round: the input word handshake and the output word handshake.
// The master drives words in and accepts results; the slave is the rounding/saturation block.
interface fixed_point_sat_round_if #(
    parameter int W_IN  = 18,
    parameter int W_OUT = 11
);
    logic             in_valid;
    logic             in_ready;
    logic [W_IN-1:0]  in_data;
    logic             in_overflow;
    logic             out_valid;
    logic             out_ready;
    logic [W_OUT-1:0] out_data;
    logic             out_sat;

    modport master (
        output in_valid, in_data, in_overflow, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_overflow, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/fixed_point_sat_round.sv
// Fixed-point narrowing: shift, saturate and buffer adder results, counting saturated words.
// Define FXP_ROUND_EN to round half up before the shift; otherwise the shift truncates toward -inf.
module fixed_point_sat_round #(
    parameter int IN_INT     = 4,
    parameter int IN_FRAC    = 14,
    parameter int OUT_INT    = 3,
    parameter int OUT_FRAC   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    fixed_point_sat_round_if.slave  bus,
    output logic [15:0]             sat_count,
    input  logic                    clear_count
);
    localparam int W_IN  = IN_INT + IN_FRAC;
    localparam int W_OUT = OUT_INT + OUT_FRAC;
    localparam int S     = IN_FRAC - OUT_FRAC;
    localparam int W1    = W_IN + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 2;

    localparam logic signed [W1-1:0] SAT_MAX = W1'((1 << (W_OUT - 1)) - 1);
    localparam logic signed [W1-1:0] SAT_MIN = ~SAT_MAX;

    // One extra bit of headroom keeps the rounding bias from wrapping the most positive input.
    logic signed [W1-1:0] in_ext;
    logic signed [W1-1:0] in_biased;
    logic signed [W1-1:0] in_shifted;

`ifdef FXP_ROUND_EN
    localparam logic signed [W1-1:0] RND = W1'(1) << (S - 1);
`endif

    always_comb begin
        in_ext = {bus.in_data[W_IN-1], bus.in_data};
`ifdef FXP_ROUND_EN
        in_biased = in_ext + RND;
`else
        in_biased = in_ext;
`endif
        in_shifted = in_biased >>> S;
    end

    logic                 s1_valid;
    logic signed [W1-1:0] s1_data;
    logic                 s1_ovf;
    logic                 s2_valid;
    logic [W_OUT-1:0]     s2_data;
    logic                 s2_sat;

    logic [AW:0]          count;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        occupancy;
    logic                 fifo_wr;
    logic                 fifo_rd;

    // Words still in the pipeline already own a FIFO slot, so they count toward the full limit.
    always_comb begin
        occupancy    = CW'(count) + CW'(s1_valid) + CW'(s2_valid);
        bus.in_ready = occupancy < CW'(FIFO_DEPTH);
        fifo_wr      = s2_valid;
        fifo_rd      = bus.out_valid && bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= bus.in_valid && bus.in_ready;
        end
        s1_data <= in_shifted;
        s1_ovf  <= bus.in_overflow;
    end

    logic             clamp_hi;
    logic             clamp_lo;
    logic [W_OUT-1:0] clamp_val;

    always_comb begin
        clamp_hi  = s1_data > SAT_MAX;
        clamp_lo  = s1_data < SAT_MIN;
        clamp_val = s1_data[W_OUT-1:0];
        if (clamp_hi) begin
            clamp_val = SAT_MAX[W_OUT-1:0];
        end else if (clamp_lo) begin
            clamp_val = SAT_MIN[W_OUT-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
        s2_data <= clamp_val;
        s2_sat  <= clamp_hi || clamp_lo || s1_ovf;
    end

    logic [W_OUT-1:0] mem_data [FIFO_DEPTH];
    logic             mem_sat  [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_data[wr_ptr] <= s2_data;
            mem_sat[wr_ptr]  <= s2_sat;
        end
    end

    // in_ready guarantees no write into a full FIFO, so only the four read/write cases matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        bus.out_valid = count != '0;
        bus.out_data  = bus.out_valid ? mem_data[rd_ptr] : '0;
        bus.out_sat   = bus.out_valid ? mem_sat[rd_ptr] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || clear_count) begin
            sat_count <= '0;
        end else if (fifo_wr && s2_sat && sat_count != 16'hFFFF) begin
            sat_count <= sat_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_fixed_point_sat_round.sv
// Directed bench for fixed_point_sat_round: a driver queues expected words, a monitor checks them.
// Build with the same FXP_ROUND_EN setting as the design so the rounding-dependent vectors match.
module tb_fixed_point_sat_round;
    logic        clk;
    logic        rst;
    logic        clear_count;
    logic [15:0] sat_count;

    fixed_point_sat_round_if #(.W_IN(18), .W_OUT(11)) bus ();

    fixed_point_sat_round dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .sat_count   (sat_count),
        .clear_count (clear_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] data;
        logic        sat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offer one word until accepted; the expected result is queued on the accepting cycle.
    task automatic applyStimulus(input logic [17:0] d, input logic ovf, input logic [10:0] ed, input logic es);
        bit   accepted;
        exp_t e;
        accepted        = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_data     = d;
        bus.in_overflow = ovf;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e = {ed, es};
                sb_q.push_back(e);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid    = 1'b0;
        bus.in_overflow = 1'b0;
        if (!accepted) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL accept_timeout: got in_ready 0, expected 1 within 50 cycles");
        end
    endtask

    task automatic waitDrain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (sb_q.size() == 0 && !bus.out_valid) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL drain_timeout: got %0d words pending, expected 0", sb_q.size());
        end
    endtask

    // While stalled the front word is rechecked every cycle, which also covers output stability.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("[TB] FAIL unexpected_word: got data 0x%0h, expected no word", bus.out_data);
            end else begin
                checkOutput("out_data", 32'(bus.out_data), 32'(sb_q[0].data));
                checkOutput("out_sat", 32'(bus.out_sat), 32'(sb_q[0].sat));
                if (bus.out_ready) begin
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    int   n_acc;
    exp_t e_bp;

    initial begin
        rst             = 1'b1;
        clear_count     = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_overflow = 1'b0;
        bus.out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
        checkOutput("rst_out_sat", 32'(bus.out_sat), 32'd0);
        checkOutput("rst_sat_count", 32'(sat_count), 32'd0);
        rst = 1'b0;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

        applyStimulus(18'h06000, 1'b0, 11'h180, 1'b0);
        checkOutput("lat_edge0", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_edge1", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_edge2", 32'(bus.out_valid), 32'd1);

`ifdef FXP_ROUND_EN
        applyStimulus(18'h00020, 1'b0, 11'h001, 1'b0);
`else
        applyStimulus(18'h00020, 1'b0, 11'h000, 1'b0);
`endif
        applyStimulus(18'h14000, 1'b0, 11'h3FF, 1'b1);
        applyStimulus(18'h28000, 1'b0, 11'h400, 1'b1);
        waitDrain();
        checkOutput("sat_count_two", 32'(sat_count), 32'd2);

`ifdef FXP_ROUND_EN
        applyStimulus(18'h0FFFF, 1'b0, 11'h3FF, 1'b1);
`else
        applyStimulus(18'h0FFFF, 1'b0, 11'h3FF, 1'b0);
`endif
        applyStimulus(18'h04000, 1'b1, 11'h100, 1'b1);
        waitDrain();
`ifdef FXP_ROUND_EN
        checkOutput("sat_count_four", 32'(sat_count), 32'd4);
`else
        checkOutput("sat_count_three", 32'(sat_count), 32'd3);
`endif

        clear_count = 1'b1;
        applyStimulus(18'h14000, 1'b0, 11'h3FF, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        clear_count = 1'b0;
        checkOutput("clear_wins", 32'(sat_count), 32'd0);
        waitDrain();
        checkOutput("clear_hold", 32'(sat_count), 32'd0);

        bus.out_ready = 1'b0;
        n_acc         = 0;
        for (int i = 1; i <= 6; i++) begin
            bus.in_valid    = 1'b1;
            bus.in_data     = 18'(i << 6);
            bus.in_overflow = 1'b0;
            @(negedge clk);
            if (bus.in_ready) begin
                e_bp = {11'(i), 1'b0};
                sb_q.push_back(e_bp);
                n_acc++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        checkOutput("bp_accepted", 32'(n_acc), 32'd4);
        checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bp_stall_valid", 32'(bus.out_valid), 32'd1);

        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("drain_first", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        checkOutput("drain_second", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("midrst_sat_count", 32'(sat_count), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("midrst_no_stale", 32'(bus.out_valid), 32'd0);

        applyStimulus(18'h06000, 1'b0, 11'h180, 1'b0);
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/fixed_point_sat_round.md
FIXED_POINT_SAT_ROUND -- requirements
Module: fixed_point_sat_round

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- IN_INT, 4, integer bits of the input word, including sign.
- IN_FRAC, 14, fractional bits of the input word.
- OUT_INT, 3, integer bits of the output word, including sign.
- OUT_FRAC, 8, fractional bits of the output word; legal only if OUT_FRAC < IN_FRAC.
- FIFO_DEPTH, 4, output buffer entries; a power of two, at least 2.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. W_IN = IN_INT+IN_FRAC and W_OUT = OUT_INT+OUT_FRAC.
- clk, input, 1, the single clock; all state changes on its rising edge.
- rst, input, 1, reset; synchronous and active-high.
- in_valid, input, 1, upstream word valid.
- in_ready, output, 1, block can accept a word.
- in_data, input, W_IN, signed two's-complement word from the adder stage.
- in_overflow, input, 1, adder overflow flag qualified by in_valid.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, downstream accepts a word.
- out_data, output, W_OUT, signed result after rounding and saturation.
- out_sat, output, 1, marks a word that was saturated or that carried in_overflow.
- sat_count, output, 16, count of words flagged out_sat.
- clear_count, input, 1, synchronous clear of sat_count.

Function
REQ-003 An input transfer SHALL occur only on a cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur only with out_valid=1 and out_ready=1.
REQ-004 Pipeline stage 1 SHALL register the shifted word (arithmetic shift right by S = IN_FRAC-OUT_FRAC) together with in_overflow, computed in W_IN+1 bits so the result cannot wrap.
REQ-005 Pipeline stage 2 SHALL clamp the result to [-2^(W_OUT-1), 2^(W_OUT-1)-1] and write the FIFO.
REQ-006 out_sat SHALL equal (clamp active) OR (registered in_overflow); in_overflow SHALL NOT alter the data value.
REQ-007 Latency: a word accepted at edge N, with the FIFO empty, SHALL give out_valid=1 after edge N+2.
REQ-008 Backpressure SHALL be handled as follows.
- The FIFO SHALL be first-in first-out and SHALL never drop or duplicate a word.
- in_ready = (fifo_count + valid pipeline stages) < FIFO_DEPTH, combinational.
- A simultaneous FIFO read and write when full or empty SHALL be legal and SHALL keep the count consistent.
REQ-009 When out_valid=1 and out_ready=0, out_data and out_sat SHALL stay stable until the transfer.
REQ-010 sat_count SHALL increment by 1 on each FIFO write with out_sat=1.
- It SHALL saturate at 0xFFFF and not wrap.
- clear_count=1 SHALL force 0 and SHALL win over a simultaneous increment.
REQ-011 The pipeline stages SHALL advance every cycle; stalling is handled by in_ready alone.

Reset
REQ-012 On rst=1 at a clock edge, the block SHALL clear all pipeline valid bits, the FIFO pointers and count, and sat_count.
- Output values after that edge: out_valid=0, out_data=0, out_sat=0, sat_count=0.
- in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-013 Reset asserted mid-operation SHALL discard all in-flight and buffered words; no stale word SHALL appear after reset.

Configuration
REQ-014 Macro FXP_ROUND_EN SHALL control rounding.
- Defined: before the shift, add 2^(S-1) (round half up, toward +inf), then saturate.
- Undefined: plain arithmetic shift (floor truncation).
- Latency and interface SHALL be identical in both builds.

Verification
REQ-015 Default parameters, with the values below, SHALL be covered.
- Nominal: in_data=0x06000 (1.5), in_overflow=0 -> out_data=0x180, out_sat=0, two cycles later.
- Rounding: in_data=0x00020 -> out_data=0x001 with FXP_ROUND_EN, 0x000 without.
- Saturation: in_data=0x14000 (5.0) -> 0x3FF with out_sat=1. Then in_data=0x28000 (-6.0) -> 0x400 with out_sat=1, and sat_count=2.
- Round-up overflow: in_data=0x0FFFF with FXP_ROUND_EN -> 0x3FF, out_sat=1.
- Overflow passthrough: in_data=0x04000 with in_overflow=1 -> out_data=0x100, out_sat=1.
- Backpressure: hold out_ready=0 and offer 6 words -> exactly 4 accepted and in_ready=0. Then out_ready=1 -> the 4 words drain in order, one per cycle. A pulse of rst mid-drain -> out_valid=0 next cycle and no remaining words emitted.
